// File: rtl/mc_ctrl_if.sv
// Control-unit bundle for the MCCPU multi-cycle datapath.
// master = the control unit (drives enables/selects), slave = the datapath.
interface mc_ctrl_if #(
  parameter int CNT_W = 32
);
  // datapath -> control
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             mem_ready;
  // control -> datapath
  logic             PCWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             EXTOp;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       NPCOp;
  logic             GPRSel;
  logic [1:0]       WDSel;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
           ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, illegal, state,
           instr_cnt
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, EXTOp,
           ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel, illegal, state,
           instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MCCPU datapath.
// Sequences FETCH -> DECODE -> EXE -> MEM -> WB, stalling on mem_ready.
// ALUOp/NPCOp/EXTOp/GPRSel/WDSel encodings match the single-cycle ctrl.
// Optional feature macro: MC_CTRL_INSTR_CNT_EN (retired-instruction counter).
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      rstn,
  mc_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  logic [2:0] state_q, state_d;
  logic       r_ok;
  logic [2:0] r_alu_op;
  logic       is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, legal;

  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic       ext_op, alu_src_a, gpr_sel, illegal;
  logic [1:0] alu_src_b, npc_op, wd_sel;
  logic [2:0] alu_op;

  // Decode the R-type function field into an ALU operation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    r_ok     = 1'b1;
    r_alu_op = ALU_NOP;
    case (bus.Funct)
      6'h20, 6'h21: r_alu_op = ALU_ADD;
      6'h22, 6'h23: r_alu_op = ALU_SUB;
      6'h24:        r_alu_op = ALU_AND;
      6'h25:        r_alu_op = ALU_OR;
      6'h2A:        r_alu_op = ALU_SLT;
      6'h2B:        r_alu_op = ALU_SLTU;
      default:      r_ok     = 1'b0;
    endcase
  end

  assign is_r    = (bus.Op == OP_RTYPE) && r_ok;
  assign is_addi = (bus.Op == OP_ADDI);
  assign is_ori  = (bus.Op == OP_ORI);
  assign is_lw   = (bus.Op == OP_LW);
  assign is_sw   = (bus.Op == OP_SW);
  assign is_beq  = (bus.Op == OP_BEQ);
  assign is_bne  = (bus.Op == OP_BNE);
  assign is_j    = (bus.Op == OP_J);
  assign legal   = is_r | is_addi | is_ori | is_lw | is_sw | is_beq | is_bne | is_j;

  // Next-state sequencing; unused codes 5-7 fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = legal ? S_EXE : S_FETCH;
      S_EXE: begin
        if (is_r || is_addi || is_ori) state_d = S_WB;
        else if (is_lw || is_sw)       state_d = S_MEM;
        else                           state_d = S_FETCH;
      end
      S_MEM: begin
        if (!bus.mem_ready) state_d = S_MEM;
        else if (is_lw)     state_d = S_WB;
        else                state_d = S_FETCH;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode; everything stays at its inactive default while rstn is low.
  always_comb begin
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ext_op    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = ALU_NOP;
    npc_op    = 2'b00;
    gpr_sel   = 1'b0;
    wd_sel    = 2'b00;
    illegal   = 1'b0;
    if (rstn) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: illegal = ~legal;
        S_EXE: begin
          if (is_r) begin
            alu_src_a = 1'b1;
            alu_op    = r_alu_op;
          end else if (is_addi || is_lw || is_sw) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            alu_op    = ALU_ADD;
          end else if (is_ori) begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = ALU_OR;
          end else if (is_beq || is_bne) begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            ext_op    = 1'b1;
            npc_op    = 2'b01;
            pc_write  = (is_beq & bus.Zero) | (is_bne & ~bus.Zero);
          end else if (is_j) begin
            pc_write  = 1'b1;
            npc_op    = 2'b10;
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = is_lw;
          mem_write = is_sw;
        end
        S_WB: begin
          reg_write = 1'b1;
          gpr_sel   = ~is_r;
          wd_sel    = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign bus.PCWrite  = pc_write;
  assign bus.IRWrite  = ir_write;
  assign bus.RegWrite = reg_write;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.IorD     = iord;
  assign bus.EXTOp    = ext_op;
  assign bus.ALUSrcA  = alu_src_a;
  assign bus.ALUSrcB  = alu_src_b;
  assign bus.ALUOp    = alu_op;
  assign bus.NPCOp    = npc_op;
  assign bus.GPRSel   = gpr_sel;
  assign bus.WDSel    = wd_sel;
  assign bus.illegal  = illegal;
  assign bus.state    = rstn ? state_q : S_FETCH;

`ifdef MC_CTRL_INSTR_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  assign retire = (state_q == S_WB)
                | ((state_q == S_MEM) && is_sw && bus.mem_ready)
                | ((state_q == S_EXE) && (is_beq || is_bne || is_j));

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rstn)       cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.instr_cnt = rstn ? cnt_q : '0;
`else
  assign bus.instr_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, reset corner
// sequences, and randomized instructions against an instruction-level model.
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  typedef enum int { K_R, K_ADDI, K_ORI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL } kind_e;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ext_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] npc_op;
    logic       gpr_sel;
    logic [1:0] wd_sel;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic       ready;
    logic [2:0] st;
    ctl_t       ctl;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         fetch_stall;
    int         mem_stall;
    int         cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   retired = 0;
  cyc_t trace[$];

  mc_ctrl_if #(.CNT_W(CNT_W)) bus();
  mc_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c.pc_write  = bus.PCWrite;
    c.ir_write  = bus.IRWrite;
    c.reg_write = bus.RegWrite;
    c.mem_read  = bus.MemRead;
    c.mem_write = bus.MemWrite;
    c.iord      = bus.IorD;
    c.ext_op    = bus.EXTOp;
    c.alu_src_a = bus.ALUSrcA;
    c.alu_src_b = bus.ALUSrcB;
    c.alu_op    = bus.ALUOp;
    c.npc_op    = bus.NPCOp;
    c.gpr_sel   = bus.GPRSel;
    c.wd_sel    = bus.WDSel;
    c.illegal   = bus.illegal;
    return c;
  endfunction

  function automatic logic [31:0] cnt_exp();
`ifdef MC_CTRL_INSTR_CNT_EN
    return 32'(retired % (1 << CNT_W));
`else
    return 32'd0;
`endif
  endfunction

  // Instruction class from the supported-instruction list.
  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] funct);
    case (op)
      6'h00:   return (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B}) ? K_R : K_ILL;
      6'h08:   return K_ADDI;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] funct);
    case (funct)
      6'h20, 6'h21: return 3'b001;
      6'h22, 6'h23: return 3'b010;
      6'h24:        return 3'b011;
      6'h25:        return 3'b100;
      6'h2A:        return 3'b101;
      default:      return 3'b110;
    endcase
  endfunction

  // Expected cycle-by-cycle trace of one instruction: phase list derived from
  // the instruction class, stall counts stretch FETCH and MEM.
  task automatic build_trace(input kind_e k, input logic [5:0] funct, input logic z,
                             input int fst, input int mst);
    ctl_t c;
    trace.delete();
    for (int i = 0; i <= fst; i++) begin
      c = '0;
      c.mem_read = 1'b1;
      if (i == fst) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
      trace.push_back('{(i == fst), 3'd0, c});
    end
    c = '0;
    c.illegal = (k == K_ILL);
    trace.push_back('{1'($urandom_range(0, 1)), 3'd1, c});
    if (k == K_ILL) return;
    c = '0;
    case (k)
      K_R:          begin c.alu_src_a = 1; c.alu_op = r_alu(funct); end
      K_ADDI, K_LW, K_SW: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.ext_op = 1; c.alu_op = 3'b001; end
      K_ORI:        begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 3'b100; end
      K_BEQ, K_BNE: begin
        c.alu_src_a = 1; c.alu_op = 3'b010; c.ext_op = 1; c.npc_op = 2'b01;
        c.pc_write  = (k == K_BEQ) ? z : ~z;
      end
      default:      begin c.pc_write = 1; c.npc_op = 2'b10; end
    endcase
    trace.push_back('{1'($urandom_range(0, 1)), 3'd2, c});
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= mst; i++) begin
        c = '0;
        c.iord      = 1'b1;
        c.mem_read  = (k == K_LW);
        c.mem_write = (k == K_SW);
        trace.push_back('{(i == mst), 3'd3, c});
      end
    end
    if (k inside {K_R, K_ADDI, K_ORI, K_LW}) begin
      c = '0;
      c.reg_write = 1'b1;
      c.gpr_sel   = (k != K_R);
      c.wd_sel    = (k == K_LW) ? 2'b01 : 2'b00;
      trace.push_back('{1'($urandom_range(0, 1)), 3'd4, c});
    end
  endtask

  // Run one instruction from FETCH (called #1 after a rising edge) and
  // compare every cycle; returns the measured cycle count.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] funct,
                           input logic z, input int fst, input int mst, output int cyc);
    kind_e k;
    bit    left;
    k = classify(op, funct);
    build_trace(k, funct, z, fst, mst);
    bus.Op = op; bus.Funct = funct; bus.Zero = z;
    cyc  = 0;
    left = 0;
    forever begin
      bus.mem_ready = (cyc < trace.size()) ? trace[cyc].ready : 1'b1;
      @(negedge clk);
      if (cyc < trace.size()) begin
        check($sformatf("%s c%0d ctl", name, cyc), 32'(dut_ctl()), 32'(trace[cyc].ctl));
        check($sformatf("%s c%0d state", name, cyc), 32'(bus.state), 32'(trace[cyc].st));
      end
      if (bus.state != 3'd0) left = 1;
      @(posedge clk); #1;
      cyc++;
      if (left && bus.state == 3'd0) break;
      if (cyc > 60) begin
        check($sformatf("%s timeout", name), 32'(cyc), 32'(trace.size()));
        break;
      end
    end
    if (k != K_ILL) retired++;
    check($sformatf("%s latency", name), 32'(cyc), 32'(trace.size()));
    check($sformatf("%s instr_cnt", name), 32'(bus.instr_cnt), cnt_exp());
  endtask

  // Hold rstn low for n edges with mem_ready high; outputs must read as zero.
  task automatic do_reset(input int n);
    rstn = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d ctl", i), 32'(dut_ctl()), 32'd0);
      check($sformatf("reset%0d state", i), 32'(bus.state), 32'd0);
      check($sformatf("reset%0d cnt", i), 32'(bus.instr_cnt), 32'd0);
      @(posedge clk); #1;
    end
    rstn = 1'b1;
    retired = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[14];
    int   cyc;
    logic [5:0] ops [11];
    logic [5:0] fns [9];

    tbl[0]  = '{"add",      6'h00, 6'h20, 1'b0, 0, 0, 4};
    tbl[1]  = '{"lw_stall", 6'h23, 6'h00, 1'b0, 0, 2, 7};
    tbl[2]  = '{"beq_z1",   6'h04, 6'h00, 1'b1, 0, 0, 3};
    tbl[3]  = '{"beq_z0",   6'h04, 6'h00, 1'b0, 0, 0, 3};
    tbl[4]  = '{"bne_z0",   6'h05, 6'h00, 1'b0, 0, 0, 3};
    tbl[5]  = '{"bne_z1",   6'h05, 6'h00, 1'b1, 0, 0, 3};
    tbl[6]  = '{"ill_3f",   6'h3F, 6'h00, 1'b0, 0, 0, 2};
    tbl[7]  = '{"sw_stall", 6'h2B, 6'h00, 1'b0, 0, 1, 5};
    tbl[8]  = '{"j",        6'h02, 6'h00, 1'b0, 0, 0, 3};
    tbl[9]  = '{"addi_fst", 6'h08, 6'h00, 1'b0, 2, 0, 6};
    tbl[10] = '{"ori",      6'h0D, 6'h00, 1'b0, 0, 0, 4};
    tbl[11] = '{"sub",      6'h00, 6'h22, 1'b1, 0, 0, 4};
    tbl[12] = '{"sltu",     6'h00, 6'h2B, 1'b0, 0, 0, 4};
    tbl[13] = '{"ill_sll",  6'h00, 6'h00, 1'b0, 0, 0, 2};

    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h08};

    bus.Op = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0; bus.mem_ready = 1'b1;
    rstn = 1'b0;
    do_reset(2);

    // Directed vectors; the first one also covers the first post-reset cycle.
    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].zero,
                tbl[i].fetch_stall, tbl[i].mem_stall, cyc);
      check($sformatf("%s cycles", tbl[i].name), 32'(cyc), 32'(tbl[i].cycles));
    end

    // Randomized instructions, zero flag and stalls.
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      run_instr($sformatf("rnd%0d_op%0h", i, op), op, fn, 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), cyc);
    end

    // Counter sequence: add, sw, j, illegal, then reset in the middle of EXE.
    do_reset(2);
    run_instr("cnt_add", 6'h00, 6'h20, 1'b0, 0, 0, cyc);
    run_instr("cnt_sw",  6'h2B, 6'h00, 1'b0, 0, 0, cyc);
    run_instr("cnt_j",   6'h02, 6'h00, 1'b0, 0, 0, cyc);
    run_instr("cnt_ill", 6'h3F, 6'h00, 1'b0, 0, 0, cyc);
`ifdef MC_CTRL_INSTR_CNT_EN
    check("cnt before reset", 32'(bus.instr_cnt), 32'd3);
`else
    check("cnt before reset", 32'(bus.instr_cnt), 32'd0);
`endif
    bus.Op = 6'h00; bus.Funct = 6'h20; bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid reset in EXE", 32'(bus.state), 32'd2);
    rstn = 1'b0;
    @(negedge clk);
    check("mid reset ctl", 32'(dut_ctl()), 32'd0);
    check("mid reset state", 32'(bus.state), 32'd0);
    check("mid reset cnt", 32'(bus.instr_cnt), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    retired = 0;
    @(negedge clk);
    check("post reset state", 32'(bus.state), 32'd0);
    check("post reset irwrite", 32'(bus.IRWrite), 32'd1);
    check("post reset cnt", 32'(bus.instr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
